// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator computer: widths, opcodes,
// register-reference bit masks and the sequence-counter state encoding.
package cpu_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int WORD_DEPTH = 4096;
  localparam int WORD_WIDTH = 16;

  // Opcode field, instruction bits 14:12
  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_REG = 3'd7
  } opcode_e;

  // Register-reference micro-operation bits, instruction bits 11:0
  localparam logic [11:0] RR_CLA = 12'h800;
  localparam logic [11:0] RR_CLE = 12'h400;
  localparam logic [11:0] RR_CMA = 12'h200;
  localparam logic [11:0] RR_CME = 12'h100;
  localparam logic [11:0] RR_CIR = 12'h080;
  localparam logic [11:0] RR_CIL = 12'h040;
  localparam logic [11:0] RR_INC = 12'h020;
  localparam logic [11:0] RR_SPA = 12'h010;
  localparam logic [11:0] RR_SNA = 12'h008;
  localparam logic [11:0] RR_SZA = 12'h004;
  localparam logic [11:0] RR_SZE = 12'h002;
  localparam logic [11:0] RR_HLT = 12'h001;

  // Sequence-counter timing states
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } seq_e;

endpackage

// File: rtl/sram.sv
// Unified program/data memory: synchronous write, combinational read.
// A read of the address being written this cycle sees the old contents.
module sram #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int WORD_DEPTH = cpu_pkg::WORD_DEPTH,
  parameter int WORD_WIDTH = cpu_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  output logic [WORD_WIDTH-1:0] o_data
);

  logic [WORD_WIDTH-1:0] mem [WORD_DEPTH];

  // Store the write data on the rising edge; contents are never reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_addr] <= i_data;
    end
  end

  assign o_data = mem[i_addr];

endmodule

// File: rtl/cpu_system.sv
// Mano-style 16-bit accumulator computer: sequence-counter FSM, decoder and
// datapath registers around a single unified memory addressed by AR.
module cpu_system
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [WORD_WIDTH-1:0] o_ac,
  output logic                  o_halt
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ar_q, ar_d;
  logic [WORD_WIDTH-1:0] ir_q, ir_d;
  logic [WORD_WIDTH-1:0] dr_q, dr_d;
  logic [WORD_WIDTH-1:0] ac_q, ac_d;
  logic                  e_q, e_d;
  logic                  i_q, i_d;
  logic                  halt_q, halt_d;
  seq_e                  sc_q, sc_d;

  logic [WORD_WIDTH-1:0] memRdata;
  logic [WORD_WIDTH-1:0] memWdata;
  logic                  memWe;

  opcode_e               opcode;
  logic [11:0]           rrBits;
  logic [WORD_WIDTH-1:0] rrAc;
  logic                  rrE;
  logic                  rrSkip;

  assign opcode = opcode_e'(ir_q[14:12]);
  assign rrBits = ir_q[11:0];

  sram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORD_DEPTH(WORD_DEPTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) sram (
    .clk   (clk),
    .i_data(memWdata),
    .i_addr(ar_q),
    .i_we  (memWe),
    .o_data(memRdata)
  );

  // Register-reference decoder: chain the AC/E micro-ops in one cycle; skip
  // conditions look at the values held before the instruction executes
  always_comb begin
    rrAc = ac_q;
    rrE  = e_q;
    if ((rrBits & RR_CLA) != 12'd0) rrAc = '0;
    if ((rrBits & RR_CLE) != 12'd0) rrE = 1'b0;
    if ((rrBits & RR_CMA) != 12'd0) rrAc = ~rrAc;
    if ((rrBits & RR_CME) != 12'd0) rrE = ~rrE;
    if ((rrBits & RR_CIR) != 12'd0) {rrAc, rrE} = {rrE, rrAc};
    if ((rrBits & RR_CIL) != 12'd0) {rrE, rrAc} = {rrAc, rrE};
    if ((rrBits & RR_INC) != 12'd0) rrAc = rrAc + 16'd1;
    rrSkip = (((rrBits & RR_SPA) != 12'd0) && !ac_q[15]) ||
             (((rrBits & RR_SNA) != 12'd0) &&  ac_q[15]) ||
             (((rrBits & RR_SZA) != 12'd0) && (ac_q == 16'd0)) ||
             (((rrBits & RR_SZE) != 12'd0) && !e_q);
  end

  // Sequence-counter next state and per-timing-state datapath transfers
  always_comb begin
    pc_d     = pc_q;
    ar_d     = ar_q;
    ir_d     = ir_q;
    dr_d     = dr_q;
    ac_d     = ac_q;
    e_d      = e_q;
    i_d      = i_q;
    halt_d   = halt_q;
    sc_d     = sc_q;
    memWe    = 1'b0;
    memWdata = ac_q;
    if (!halt_q) begin
      case (sc_q)
        T0: begin
          ar_d = pc_q;
          sc_d = T1;
        end
        T1: begin
          ir_d = memRdata;
          pc_d = pc_q + 12'd1;
          sc_d = T2;
        end
        T2: begin
          ar_d = ir_q[11:0];
          i_d  = ir_q[15];
          sc_d = T3;
        end
        T3: begin
          if (opcode == OP_REG) begin
            ac_d = rrAc;
            e_d  = rrE;
            if (rrSkip) pc_d = pc_q + 12'd1;
            if ((rrBits & RR_HLT) != 12'd0) halt_d = 1'b1;
            sc_d = T0;
          end else begin
            if (i_q) ar_d = memRdata[11:0];
            sc_d = T4;
          end
        end
        T4: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              dr_d = memRdata;
              sc_d = T5;
            end
            OP_STA: begin
              memWe    = 1'b1;
              memWdata = ac_q;
              sc_d     = T0;
            end
            OP_BUN: begin
              pc_d = ar_q;
              sc_d = T0;
            end
            OP_BSA: begin
              memWe    = 1'b1;
              memWdata = {4'b0000, pc_q};
              ar_d     = ar_q + 12'd1;
              sc_d     = T5;
            end
            default: sc_d = T0;
          endcase
        end
        T5: begin
          sc_d = T0;
          case (opcode)
            OP_AND: ac_d = ac_q & dr_q;
            OP_ADD: {e_d, ac_d} = {1'b0, ac_q} + {1'b0, dr_q};
            OP_LDA: ac_d = dr_q;
            OP_BSA: pc_d = ar_q;
            OP_ISZ: begin
              dr_d = dr_q + 16'd1;
              sc_d = T6;
            end
            default: sc_d = T0;
          endcase
        end
        T6: begin
          memWe    = 1'b1;
          memWdata = dr_q;
          if (dr_q == 16'd0) pc_d = pc_q + 12'd1;
          sc_d = T0;
        end
        default: sc_d = T0;
      endcase
    end
  end

  // CPU register file; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= '0;
      ar_q   <= '0;
      ir_q   <= '0;
      dr_q   <= '0;
      ac_q   <= '0;
      e_q    <= 1'b0;
      i_q    <= 1'b0;
      halt_q <= 1'b0;
      sc_q   <= T0;
    end else begin
      pc_q   <= pc_d;
      ar_q   <= ar_d;
      ir_q   <= ir_d;
      dr_q   <= dr_d;
      ac_q   <= ac_d;
      e_q    <= e_d;
      i_q    <= i_d;
      halt_q <= halt_d;
      sc_q   <= sc_d;
    end
  end

  assign o_pc   = pc_q;
  assign o_ac   = ac_q;
  assign o_halt = halt_q;

endmodule

// File: tb/tb_cpu_system.sv
// Directed-program bench for cpu_system: loads small programs straight into
// the memory array, runs them to HLT and compares against hand-worked results.
module tb_cpu_system;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] pc;
  logic [15:0] ac;
  logic        halt;

  int checkCount = 0;
  int passCount  = 0;
  int used;

  cpu_system dut (
    .clk    (clk),
    .reset_n(reset_n),
    .o_pc   (pc),
    .o_ac   (ac),
    .o_halt (halt)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Hold the CPU in reset and wipe the low memory region used by the programs
  task automatic startProgram();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 128; i++) dut.sram.mem[i] = 16'h0000;
  endtask

  task automatic loadWord(input logic [11:0] addr, input logic [15:0] word);
    dut.sram.mem[addr] = word;
  endtask

  // Release reset on a falling edge, then run until HLT or the cycle budget
  task automatic applyStimulus(input string tag, input int budget, output int cycles);
    @(negedge clk);
    reset_n = 1'b1;
    cycles = 0;
    while (!halt && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_halted"}, {31'd0, halt}, 32'd1);
  endtask

  // Unrolled sum of mem[100..109]=1..10 into mem[99]; HLT sits at address 11
  task automatic loadSumProgram();
    loadWord(12'd0, 16'h2064);
    for (int k = 0; k < 9; k++) loadWord(12'(1 + k), 16'(16'h1065 + k));
    loadWord(12'd10, 16'h3063);
    loadWord(12'd11, 16'h7001);
    for (int k = 0; k < 10; k++) loadWord(12'(100 + k), 16'(k + 1));
  endtask

  // Reg-ref program: LDA 0x8001, then the listed micro-ops, then HLT
  task automatic loadRegProgram(input int steps);
    loadWord(12'd0, 16'h200A);
    loadWord(12'd10, 16'h8001);
    loadWord(12'd1, 16'h7040);
    loadWord(12'd2, 16'h7080);
    loadWord(12'd3, 16'h7008);
    loadWord(12'd4, 16'h7800);
    loadWord(12'd5, 16'h7001);
    loadWord(12'(1 + steps), 16'h7001);
  endtask

  initial begin
    // Reset asserted from time 0, checked 1 ns in, before the first edge
    startProgram();
    checkOutput("resetPc", {20'd0, pc}, 32'd0);
    checkOutput("resetAc", {16'd0, ac}, 32'd0);
    checkOutput("resetHalt", {31'd0, halt}, 32'd0);

    // Unrolled sum: 6 + 9*6 + 5 + 4 = 69 cycles, PC left at 12 after HLT
    loadSumProgram();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("firstFetchPc", {20'd0, pc}, 32'd1);
    used = 2;
    while (!halt && used < 200) begin
      @(negedge clk);
      used++;
    end
    checkOutput("sumHalted", {31'd0, halt}, 32'd1);
    checkOutput("sumCycles", used, 32'd69);
    checkOutput("sumMem99", {16'd0, dut.sram.mem[99]}, 32'd55);
    checkOutput("sumAc", {16'd0, ac}, 32'd55);
    checkOutput("sumPc", {20'd0, pc}, 32'd12);
    repeat (10) @(negedge clk);
    checkOutput("sumFrozenPc", {20'd0, pc}, 32'd12);
    checkOutput("sumFrozenHalt", {31'd0, halt}, 32'd1);

    // Indirect load of 0xFFFF plus 1: AC wraps to 0 with carry into E
    startProgram();
    loadWord(12'd0, 16'hA005);
    loadWord(12'd1, 16'h1006);
    loadWord(12'd2, 16'h7001);
    loadWord(12'd5, 16'h0064);
    loadWord(12'd6, 16'h0001);
    loadWord(12'd100, 16'hFFFF);
    applyStimulus("indirect", 200, used);
    checkOutput("indirectAc", {16'd0, ac}, 32'h0000);
    checkOutput("indirectE", {31'd0, dut.e_q}, 32'd1);
    checkOutput("indirectPc", {20'd0, pc}, 32'd3);
    checkOutput("indirectCycles", used, 32'd16);

    // CIL on 0x8001/E=0 gives 0x0002/E=1
    startProgram();
    loadRegProgram(1);
    applyStimulus("cil", 200, used);
    checkOutput("cilAc", {16'd0, ac}, 32'h0002);
    checkOutput("cilE", {31'd0, dut.e_q}, 32'd1);

    // CIR rotates it back to 0x8001/E=0
    startProgram();
    loadRegProgram(2);
    applyStimulus("cir", 200, used);
    checkOutput("cirAc", {16'd0, ac}, 32'h8001);
    checkOutput("cirE", {31'd0, dut.e_q}, 32'd0);

    // SNA with AC negative skips the CLA at address 4 and lands on HLT at 5
    startProgram();
    loadRegProgram(4);
    applyStimulus("sna", 200, used);
    checkOutput("snaAc", {16'd0, ac}, 32'h8001);
    checkOutput("snaPc", {20'd0, pc}, 32'd6);

    // Pointer/counter loop over 10..100, then BSA to an INC subroutine that
    // returns through BUN I; 9*25 + 20 + 5 + 6 + 4 + 5 + 4 = 269 cycles
    startProgram();
    loadWord(12'd0, 16'h9028);
    loadWord(12'd1, 16'h6028);
    loadWord(12'd2, 16'h6029);
    loadWord(12'd3, 16'h4000);
    loadWord(12'd4, 16'h3063);
    loadWord(12'd5, 16'h5032);
    loadWord(12'd6, 16'h7001);
    loadWord(12'd40, 16'd100);
    loadWord(12'd41, 16'hFFF6);
    loadWord(12'd51, 16'h7020);
    loadWord(12'd52, 16'hC032);
    for (int k = 0; k < 10; k++) loadWord(12'(100 + k), 16'(10 * (k + 1)));
    applyStimulus("loop", 1000, used);
    checkOutput("loopMem99", {16'd0, dut.sram.mem[99]}, 32'd550);
    checkOutput("loopReturnAddr", {16'd0, dut.sram.mem[50]}, 32'd6);
    checkOutput("loopCounter", {16'd0, dut.sram.mem[41]}, 32'd0);
    checkOutput("loopPointer", {16'd0, dut.sram.mem[40]}, 32'd110);
    checkOutput("loopAc", {16'd0, ac}, 32'd551);
    checkOutput("loopPc", {20'd0, pc}, 32'd7);
    checkOutput("loopCycles", used, 32'd269);

    // Reset during T4 of the first ADD (edge 11 would execute it)
    startProgram();
    loadSumProgram();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midRunState", {29'd0, dut.sc_q}, 32'd4);
    checkOutput("midRunAcBefore", {16'd0, ac}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midRunResetPc", {20'd0, pc}, 32'd0);
    checkOutput("midRunResetAc", {16'd0, ac}, 32'd0);
    checkOutput("midRunMemKept", {16'd0, dut.sram.mem[100]}, 32'd1);
    applyStimulus("restart", 200, used);
    checkOutput("restartMem99", {16'd0, dut.sram.mem[99]}, 32'd55);
    checkOutput("restartPc", {20'd0, pc}, 32'd12);
    checkOutput("restartCycles", used, 32'd69);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
